digit_match_score: RTL and testbench
====================================

# digit_match_score

Pixel-stream template scorer for the number-recognition path. It accumulates, per character region (ROI), how many binarised pixels agree with each of ten digit templates. It snapshots the ten 12-bit scores onto `match_0`..`match_9` and drives the 3-bit `cnt` phase sequence that the downstream max-score comparator tree consumes. It sits between the binarisation/ROI-cropping stage and the max/argmax stage, all on `pclk`.

## Interface
- `SCORE_W`, 12: width of each score and accumulator; must equal the comparator input width.
- `pclk` in 1: pixel clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `roi_start` in 1: one-cycle pulse; first pixel of a new ROI; clears accumulators.
- `pix_valid` in 1: `pix_bit`/`tmpl_bits` valid this cycle.
- `pix_bit` in 1: binarised pixel (1 = foreground).
- `tmpl_bits` in 10: bit i = template-i value at the current pixel position, aligned with `pix_bit`.
- `pix_last` in 1: qualifies the last pixel of the ROI (meaningful only with `pix_valid`).
- `match_0`..`match_9` out `SCORE_W` each: snapshot scores, held stable between snapshots.
- `cnt` out 3: comparator phase; 0,1,2,3,0 during evaluation, 4 when idle.
- `eval_busy` out 1: high while `cnt` != 4.
- `max_done` out 1: one-cycle pulse; downstream `max` is valid this cycle.
- `overrun` out 1: one-cycle pulse; a new snapshot preempted an unfinished evaluation.

## Operation
- Per-pixel hit vector: `hit[i] = pix_valid & ~(pix_bit ^ tmpl_bits[i])`.
- Accumulators `acc[i]` are `SCORE_W` bits and saturate at 2^`SCORE_W`-1 (4095); they never wrap.
- `roi_start` with `pix_valid`: `acc[i] <= hit[i]` (0 or 1). `roi_start` without `pix_valid`: `acc[i] <= 0`.
- Otherwise, `pix_valid`: `acc[i] <= sat(acc[i]+hit[i])`.
- Snapshot on `pix_valid & pix_last`: `match_i <= sat(acc[i]+hit[i])`, or `hit[i]` if `roi_start` is also high. Accumulators update as normal.
- Accumulation of the next ROI runs independently of the evaluation sequence. Pixels are never stalled or dropped.
- Evaluation FSM:
  - IDLE (`cnt`=4).
  - EVAL: phases P0, P1, P2, P3, P4 output `cnt` = 0, 1, 2, 3, 0.
- Transitions:
  - IDLE→P0 on snapshot.
  - Pn→Pn+1 unconditionally.
  - P4→IDLE; `max_done` <= 1 at that edge.
- Snapshot while in EVAL: `match_i` reloaded, FSM → P0, `overrun` pulses for one cycle, and the pending `max_done` is cancelled.
- `pix_last` without `pix_valid` is ignored.
- `roi_start` never aborts an evaluation; only a snapshot does.

## Timing
- Reset values:
  - `match_0`..`match_9` = 0; `acc` = 0.
  - `cnt` = 4; FSM IDLE.
  - `eval_busy` = 0; `max_done` = 0; `overrun` = 0.
- All outputs are registered; no combinational input→output paths.
- Snapshot accepted at edge k:
  - `match_i` is valid from cycle k+1.
  - `cnt` = 0,1,2,3,0 in cycles k+1..k+5.
  - `max_done` is high in cycle k+6 with `cnt` = 4.
  - Latency from last pixel to `max_done` is 6 cycles.
- `match_i` holds constant from k+1 through at least k+5 unless preempted.
- Minimum ROI spacing without overrun: 6 cycles between `pix_last` beats.
- `overrun` is high the cycle after the preempting edge, coincident with `cnt` = 0.
- `rst_n` low mid-ROI or mid-EVAL asynchronously forces all reset values. The first ROI after release requires `roi_start` (acc is already 0).

## Test plan
- Perfect match:
  - Stimulus: `roi_start`, 16 pixels with `tmpl_bits[3]` = `pix_bit` and every other bit inverted; `pix_last` on pixel 16.
  - Required: `match_3` = 16, all others = 0; `cnt` 0,1,2,3,0 then 4; `max_done` exactly 6 cycles after the `pix_last` edge; downstream `max` = 16.
- Saturation: 5000-pixel ROI with `tmpl_bits` = 10'h3FF and `pix_bit` = 1 → every `match_i` = 4095, no wrap.
- Gaps and single pixel:
  - ROI with `pix_valid` deasserted for 3 cycles mid-stream → scores unchanged versus the gap-free run.
  - `roi_start`, `pix_valid` and `pix_last` in the same cycle with `pix_bit` = 1, `tmpl_bits` = 10'h001 → `match_0` = 1, others 0.
- Back-to-back ROIs:
  - Second `pix_last` 3 cycles after the first → `overrun` pulse; `match_i` shows the second ROI; one `max_done` only, 6 cycles after the second `pix_last`.
  - Spacing of 6 cycles → no `overrun`, two `max_done` pulses.
- Reset mid-EVAL: drop `rst_n` in the `cnt` = 2 cycle → immediately `cnt` = 4, `match_i` = 0, `eval_busy` = 0; no `max_done` after release.
- Next-ROI overlap: the next ROI's pixels arrive during EVAL → `match_i` stays stable through `cnt` = 0..3..0, and the next snapshot is correct.

Source files
------------

// File: rtl/digit_match_score.sv
// Per-ROI template agreement scorer: ten saturating accumulators, a snapshot
// register bank and the 0,1,2,3,0 phase sequencer for the max comparator tree.
module digit_match_score #(
  parameter int SCORE_W = 12
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               roi_start,
  input  logic               pix_valid,
  input  logic               pix_bit,
  input  logic [9:0]         tmpl_bits,
  input  logic               pix_last,
  output logic [SCORE_W-1:0] match_0,
  output logic [SCORE_W-1:0] match_1,
  output logic [SCORE_W-1:0] match_2,
  output logic [SCORE_W-1:0] match_3,
  output logic [SCORE_W-1:0] match_4,
  output logic [SCORE_W-1:0] match_5,
  output logic [SCORE_W-1:0] match_6,
  output logic [SCORE_W-1:0] match_7,
  output logic [SCORE_W-1:0] match_8,
  output logic [SCORE_W-1:0] match_9,
  output logic [2:0]         cnt,
  output logic               eval_busy,
  output logic               max_done,
  output logic               overrun
);

  // state | meaning
  // IDLE  | no evaluation, cnt = 4
  // P0-P3 | comparator phases, cnt = 0..3
  // P4    | final phase, cnt = 0; max_done follows
  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4} state_t;

  localparam logic [SCORE_W-1:0] SAT = '1;

  logic [9:0]         hit;
  logic               snap;
  logic [SCORE_W-1:0] acc     [10];
  logic [SCORE_W-1:0] acc_nxt [10];
  logic [SCORE_W-1:0] match_r [10];
  state_t             state, state_nxt;
  logic [2:0]         cnt_nxt;
  logic               done_nxt, ovr_nxt;

  assign hit  = {10{pix_valid}} & ~({10{pix_bit}} ^ tmpl_bits);
  assign snap = pix_valid & pix_last;

  // hit is already gated by pix_valid, so roi_start alone loads zero
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      acc_nxt[i] = acc[i];
      if (roi_start)
        acc_nxt[i] = {{(SCORE_W-1){1'b0}}, hit[i]};
      else if (hit[i] && (acc[i] != SAT))
        acc_nxt[i] = acc[i] + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) begin
        acc[i]     <= '0;
        match_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 10; i++) begin
        acc[i] <= acc_nxt[i];
        if (snap) match_r[i] <= acc_nxt[i];
      end
    end
  end

  assign match_0 = match_r[0];
  assign match_1 = match_r[1];
  assign match_2 = match_r[2];
  assign match_3 = match_r[3];
  assign match_4 = match_r[4];
  assign match_5 = match_r[5];
  assign match_6 = match_r[6];
  assign match_7 = match_r[7];
  assign match_8 = match_r[8];
  assign match_9 = match_r[9];

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    case (state)
      S_P0:    state_nxt = S_P1;
      S_P1:    state_nxt = S_P2;
      S_P2:    state_nxt = S_P3;
      S_P3:    state_nxt = S_P4;
      S_P4: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // a new snapshot restarts the sequence and cancels any pending max_done
    if (snap) begin
      state_nxt = S_P0;
      done_nxt  = 1'b0;
      ovr_nxt   = (state != S_IDLE);
    end
    case (state_nxt)
      S_P1:    cnt_nxt = 3'd1;
      S_P2:    cnt_nxt = 3'd2;
      S_P3:    cnt_nxt = 3'd3;
      S_P0,
      S_P4:    cnt_nxt = 3'd0;
      default: cnt_nxt = 3'd4;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 3'd4;
      eval_busy <= 1'b0;
      max_done  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      eval_busy <= (state_nxt != S_IDLE);
      max_done  <= done_nxt;
      overrun   <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_digit_match_score.sv
// Scoreboard bench for digit_match_score: stimulus queues expected scores and
// max_done cycle per ROI; a negedge monitor pops and checks on each max_done.
module tb_digit_match_score;
  localparam int W = 12;

  logic         pclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         roi_start = 1'b0, pix_valid = 1'b0, pix_bit = 1'b0, pix_last = 1'b0;
  logic [9:0]   tmpl_bits = '0;
  logic [W-1:0] match_0, match_1, match_2, match_3, match_4;
  logic [W-1:0] match_5, match_6, match_7, match_8, match_9;
  logic [2:0]   cnt;
  logic         eval_busy, max_done, overrun;

  digit_match_score #(.SCORE_W(W)) dut (
    .pclk(pclk), .rst_n(rst_n), .roi_start(roi_start), .pix_valid(pix_valid),
    .pix_bit(pix_bit), .tmpl_bits(tmpl_bits), .pix_last(pix_last),
    .match_0(match_0), .match_1(match_1), .match_2(match_2), .match_3(match_3),
    .match_4(match_4), .match_5(match_5), .match_6(match_6), .match_7(match_7),
    .match_8(match_8), .match_9(match_9),
    .cnt(cnt), .eval_busy(eval_busy), .max_done(max_done), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic [W-1:0] m [10];
  assign m[0] = match_0; assign m[1] = match_1; assign m[2] = match_2;
  assign m[3] = match_3; assign m[4] = match_4; assign m[5] = match_5;
  assign m[6] = match_6; assign m[7] = match_7; assign m[8] = match_8;
  assign m[9] = match_9;

  typedef struct packed {
    logic [9:0][W-1:0] s;
    logic [31:0]       done;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0, fails = 0;
  int   act_ovr = 0, act_done = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor
  logic [W-1:0] prev_m [10];
  logic [2:0]   prev_cnt = 3'd4;
  always @(negedge pclk) begin
    if (rst_n) begin
      if (overrun) begin
        act_ovr++;
        chk("overrun_with_cnt0", int'(cnt), 0);
      end
      // scores must stay frozen during evaluation except where a new one starts
      if (eval_busy && !(cnt == 3'd0 && (prev_cnt != 3'd3 || overrun)))
        for (int i = 0; i < 10; i++)
          chk($sformatf("stable_match_%0d", i), int'(m[i]), int'(prev_m[i]));
      if (max_done) begin
        act_done++;
        chk("done_cnt_idle", int'(cnt), 4);
        chk("done_busy_low", int'(eval_busy), 0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_max_done actual=pulse required=none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, int'(mon_e.done));
          for (int i = 0; i < 10; i++)
            chk($sformatf("match_%0d", i), int'(m[i]), int'(mon_e.s[i]));
        end
      end
    end
    prev_cnt = cnt;
    for (int i = 0; i < 10; i++) prev_m[i] = m[i];
  end

  task automatic px(input logic rs, input logic v, input logic b,
                    input logic [9:0] t, input logic l);
    @(negedge pclk);
    roi_start = rs; pix_valid = v; pix_bit = b; tmpl_bits = t; pix_last = l;
  endtask

  task automatic quiet();
    px(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
  endtask

  // called in the same negedge slot as the pix_last beat
  task automatic expect_roi(input logic [9:0][W-1:0] s);
    exp_t e;
    e.s = s;
    e.done = 32'(cyc + 6);
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge pclk);
  endtask

  function automatic logic [9:0][W-1:0] all_v(input int v);
    logic [9:0][W-1:0] r;
    for (int i = 0; i < 10; i++) r[i] = W'(v);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0][W-1:0] s;
    int   exp_cnt [6] = '{0, 1, 2, 3, 0, 4};
    int   o0, d0, n, mx;
    logic b;

    repeat (3) @(negedge pclk);
    chk("rst_cnt", int'(cnt), 4);
    chk("rst_busy", int'(eval_busy), 0);
    chk("rst_done", int'(max_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    for (int i = 0; i < 10; i++) chk($sformatf("rst_match_%0d", i), int'(m[i]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);

    // perfect match on template 3
    for (int p = 0; p < 16; p++) begin
      b = p[0];
      px(p == 0, 1'b1, b, {10{b}} ^ 10'h3F7, p == 15);
    end
    s = all_v(0); s[3] = 12'd16;
    expect_roi(s);
    for (int j = 0; j < 6; j++) begin
      quiet();
      chk($sformatf("perfect_cnt_%0d", j), int'(cnt), exp_cnt[j]);
    end
    mx = 0;
    for (int i = 0; i < 10; i++) if (int'(m[i]) > mx) mx = int'(m[i]);
    chk("perfect_max", mx, 16);
    drain(20);

    // saturation
    for (int p = 0; p < 5000; p++) px(p == 0, 1'b1, 1'b1, 10'h3FF, p == 4999);
    expect_roi(all_v(4095));
    quiet();
    drain(20);

    // gap-free reference: even templates 5, odd 3
    for (int i = 0; i < 10; i++) s[i] = i[0] ? 12'd3 : 12'd5;
    for (int p = 0; p < 8; p++) px(p == 0, 1'b1, p < 5, 10'h155, p == 7);
    expect_roi(s);
    quiet();
    drain(20);

    // same ROI with a 3-cycle gap; idle beats carry a stray pix_last
    for (int p = 0; p < 8; p++) begin
      px(p == 0, 1'b1, p < 5, 10'h155, p == 7);
      if (p == 7) expect_roi(s);
      if (p == 3) repeat (3) px(1'b0, 1'b0, 1'b1, 10'h155, 1'b1);
    end
    quiet();
    drain(20);

    // single-pixel ROI
    px(1'b1, 1'b1, 1'b1, 10'h001, 1'b1);
    s = all_v(0); s[0] = 12'd1;
    expect_roi(s);
    quiet();
    drain(20);

    // overrun: second pix_last 3 cycles after the first
    o0 = act_ovr; d0 = act_done;
    px(1'b1, 1'b1, 1'b1, 10'h3FF, 1'b0);
    px(1'b0, 1'b1, 1'b1, 10'h3FF, 1'b1);
    px(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    px(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    px(1'b0, 1'b1, 1'b0, 10'h000, 1'b1);
    expect_roi(all_v(3));
    quiet();
    drain(30);
    chk("overrun_pulses", act_ovr - o0, 1);
    chk("overrun_done_pulses", act_done - d0, 1);

    // 6-cycle spacing with next ROI accumulating during evaluation
    o0 = act_ovr; d0 = act_done;
    for (int p = 0; p < 4; p++) px(p == 0, 1'b1, 1'b1, 10'h00F, p == 3);
    s = all_v(0); for (int i = 0; i < 4; i++) s[i] = 12'd4;
    expect_roi(s);
    for (int p = 0; p < 6; p++) px(p == 0, 1'b1, 1'b0, 10'h00F, p == 5);
    s = all_v(6); for (int i = 0; i < 4; i++) s[i] = 12'd0;
    expect_roi(s);
    quiet();
    drain(30);
    chk("spaced_overrun_pulses", act_ovr - o0, 0);
    chk("spaced_done_pulses", act_done - d0, 2);

    // reset in the cnt = 2 cycle
    px(1'b1, 1'b1, 1'b1, 10'h3FF, 1'b1);
    expect_roi(all_v(1));
    quiet();
    n = 0;
    while (cnt != 3'd2 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    chk("reach_cnt2", int'(cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_cnt", int'(cnt), 4);
    chk("midreset_busy", int'(eval_busy), 0);
    chk("midreset_done", int'(max_done), 0);
    for (int i = 0; i < 10; i++) chk($sformatf("midreset_match_%0d", i), int'(m[i]), 0);
    sb.delete();
    d0 = act_done;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    repeat (10) @(negedge pclk);
    chk("post_reset_done_pulses", act_done - d0, 0);

    // first ROI after reset
    px(1'b1, 1'b1, 1'b0, 10'h3FE, 1'b1);
    s = all_v(0); s[0] = 12'd1;
    expect_roi(s);
    quiet();
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
